// File: rtl/spec_rf_pkg.sv
// Shared constants, saturating helpers and the buffered-entry layout for the
// speculative register-file buffer.
//   *_D constants : default parameter values used by spec_rf_buf
//   sat_sub_order : order tag minus retired memory ops, floored at 0
//   sat_sub_level : branch level minus resolved branches, floored at 0
//   rf_entry_t    : {sel, order, level, data} at the default widths
package spec_rf_pkg;

  localparam int XLEN_D        = 32;
  localparam int NREG_D        = 32;
  localparam int IN_LEN_D      = 4;
  localparam int BUF_LEN_D     = 8;
  localparam int COMMIT_LEN_D  = 2;
  localparam int MEM_LEN_D     = 2;
  localparam int ORD_W_D       = 3;
  localparam int LVL_W_D       = 2;
  localparam int RD_PORTS_D    = 8;
  localparam int EXTRA_PORTS_D = 2;

  localparam int RGBIT_D = $clog2(NREG_D);
  localparam int CNT_W_D = $clog2(BUF_LEN_D + 1);
  localparam int REL_W_D = $clog2(MEM_LEN_D + 1);

  function automatic int unsigned sat_sub_order(input int unsigned order,
                                                input int unsigned rel);
    return (order > rel) ? order - rel : 0;
  endfunction

  function automatic int unsigned sat_sub_level(input int unsigned level,
                                                input int unsigned dec);
    return (level > dec) ? level - dec : 0;
  endfunction

  typedef struct packed {
    logic [RGBIT_D-1:0] sel;
    logic [ORD_W_D-1:0] order;
    logic [LVL_W_D-1:0] level;
    logic [XLEN_D-1:0]  data;
  } rf_entry_t;

endpackage

// File: rtl/spec_rf_fwd.sv
// Priority forwarding mux for one read port.
//   sel                    : register to read (0 always returns 0)
//   mem_sel/mem_data       : direct bank write lanes this cycle, highest priority
//   buf_vld/sel/level/data : buffer contents, index 0 oldest
//   bank                   : architectural bank
//   data                   : forwarded value
// LVL_FILTER=1 restricts buffer hits to entries with no unresolved branch.
module spec_rf_fwd #(
  parameter int XLEN       = 32,
  parameter int NREG       = 32,
  parameter int BUF_LEN    = 8,
  parameter int MEM_LEN    = 2,
  parameter int LVL_W      = 2,
  parameter bit LVL_FILTER = 1'b0,
  localparam int RGBIT     = $clog2(NREG)
) (
  input  logic [RGBIT-1:0]                  sel,
  input  logic [MEM_LEN-1:0][RGBIT-1:0]     mem_sel,
  input  logic [MEM_LEN-1:0][XLEN-1:0]      mem_data,
  input  logic [BUF_LEN-1:0]                buf_vld,
  input  logic [BUF_LEN-1:0][RGBIT-1:0]     buf_sel,
  input  logic [BUF_LEN-1:0][LVL_W-1:0]     buf_level,
  input  logic [BUF_LEN-1:0][XLEN-1:0]      buf_data,
  input  logic [NREG-1:0][XLEN-1:0]         bank,
  output logic [XLEN-1:0]                   data
);

  // Later assignments override earlier ones, so scanning oldest->youngest and
  // low->high lane gives youngest-buffer and highest-lane priority.
  always_comb begin
    data = bank[sel];
    for (int i = 0; i < BUF_LEN; i++) begin
      if (buf_vld[i] && (buf_sel[i] == sel) &&
          (!LVL_FILTER || (buf_level[i] == '0)))
        data = buf_data[i];
    end
    for (int m = 0; m < MEM_LEN; m++) begin
      if (mem_sel[m] == sel)
        data = mem_data[m];
    end
    if (sel == '0)
      data = '0;
  end

endmodule

// File: rtl/spec_rf_buf.sv
// Register file with a speculative write-back buffer.
//   in_*           : exec write-back lanes (sel 0 = idle); accepted as a group
//                    only while in_ready is high, otherwise dropped + err_ovf
//   mem_*, csr_*   : direct bank writes next edge, csr replaces mem lane 0
//   mem_release    : memory ops retired, ages buffered order tags
//   level_decrease : oldest branch resolved, ages buffered level tags
//   level_clear    : mispredict, kills entries under any unresolved branch
//   clear_pipeline : flush, kills every not-yet-eligible entry
//   rd_* / ex_*    : combinational reads; ex ports ignore speculative entries
//   buf_count, pend_list, in_ready : registered occupancy views
//   err_ovf        : sticky overflow until rst
module spec_rf_buf import spec_rf_pkg::*; #(
  parameter int XLEN        = XLEN_D,
  parameter int NREG        = NREG_D,
  parameter int IN_LEN      = IN_LEN_D,
  parameter int BUF_LEN     = BUF_LEN_D,
  parameter int COMMIT_LEN  = COMMIT_LEN_D,
  parameter int MEM_LEN     = MEM_LEN_D,
  parameter int ORD_W       = ORD_W_D,
  parameter int LVL_W       = LVL_W_D,
  parameter int RD_PORTS    = RD_PORTS_D,
  parameter int EXTRA_PORTS = EXTRA_PORTS_D,
  localparam int RGBIT      = $clog2(NREG),
  localparam int CNT_W      = $clog2(BUF_LEN + 1),
  localparam int REL_W      = $clog2(MEM_LEN + 1)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [IN_LEN-1:0][RGBIT-1:0]       in_sel,
  input  logic [IN_LEN-1:0][ORD_W-1:0]       in_order,
  input  logic [IN_LEN-1:0][LVL_W-1:0]       in_level,
  input  logic [IN_LEN-1:0][XLEN-1:0]        in_data,
  output logic                               in_ready,
  input  logic [MEM_LEN-1:0][RGBIT-1:0]      mem_sel,
  input  logic [MEM_LEN-1:0][XLEN-1:0]       mem_data,
  input  logic                               csr_vld,
  input  logic [RGBIT-1:0]                   csr_sel,
  input  logic [XLEN-1:0]                    csr_data,
  input  logic [REL_W-1:0]                   mem_release,
  input  logic                               level_decrease,
  input  logic                               level_clear,
  input  logic                               clear_pipeline,
  input  logic [RD_PORTS-1:0][RGBIT-1:0]     rd_sel,
  output logic [RD_PORTS-1:0][XLEN-1:0]      rd_data,
  input  logic [EXTRA_PORTS-1:0][RGBIT-1:0]  ex_sel,
  output logic [EXTRA_PORTS-1:0][XLEN-1:0]   ex_data,
  output logic [CNT_W-1:0]                   buf_count,
  output logic [NREG-1:0]                    pend_list,
  output logic                               err_ovf
);

  localparam int IDX_W = (BUF_LEN > 1) ? $clog2(BUF_LEN) : 1;

  typedef struct packed {
    logic [RGBIT-1:0] sel;
    logic [ORD_W-1:0] order;
    logic [LVL_W-1:0] level;
    logic [XLEN-1:0]  data;
  } ent_t;

  ent_t [BUF_LEN-1:0]            buf_q, buf_d, b_aged;
  logic [NREG-1:0][XLEN-1:0]     bank_q, bank_d;
  logic [BUF_LEN-1:0]            vld, b_elig, b_kill, b_ret;
  ent_t [IN_LEN-1:0]             i_aged;
  logic [IN_LEN-1:0]             i_elig, i_live;
  logic                          any_in, ovf_now;
  logic [CNT_W-1:0]              cnt_d;
  logic [NREG-1:0]               pend_d;
  logic                          ready_d;
  int                            nret;
  logic [MEM_LEN-1:0][RGBIT-1:0] wsel;
  logic [MEM_LEN-1:0][XLEN-1:0]  wdata;

  // Effective direct-write lanes: csr takes over lane 0.
  always_comb begin
    wsel  = mem_sel;
    wdata = mem_data;
    if (csr_vld) begin
      wsel[0]  = csr_sel;
      wdata[0] = csr_data;
    end
  end

  // Buffer ageing and kill. Eligibility uses the aged order but the
  // pre-decrement level, so a branch resolving this cycle only frees the
  // entry on the following cycle.
  always_comb begin
    vld    = '0;
    b_aged = buf_q;
    b_elig = '0;
    b_kill = '0;
    for (int i = 0; i < BUF_LEN; i++) begin
      vld[i] = CNT_W'(i) < buf_count;
      b_aged[i].order = ORD_W'(sat_sub_order(32'(buf_q[i].order), 32'(mem_release)));
      b_aged[i].level = LVL_W'(sat_sub_level(32'(buf_q[i].level), 32'(level_decrease)));
      b_elig[i] = vld[i] && (b_aged[i].order == '0) && (buf_q[i].level == '0);
      b_kill[i] = vld[i] && ((clear_pipeline && !b_elig[i]) ||
                             (level_clear && (buf_q[i].level != '0)));
    end
  end

  // Oldest-first retirement, at most COMMIT_LEN per cycle.
  always_comb begin
    b_ret = '0;
    nret  = 0;
    for (int i = 0; i < BUF_LEN; i++) begin
      if (b_elig[i] && (nret < COMMIT_LEN)) begin
        b_ret[i] = 1'b1;
        nret     = nret + 1;
      end
    end
  end

  // Incoming lanes age and get killed exactly like buffered entries, but are
  // never retired in their arrival cycle.
  always_comb begin
    any_in = 1'b0;
    i_elig = '0;
    i_live = '0;
    for (int j = 0; j < IN_LEN; j++) begin
      i_aged[j].sel   = in_sel[j];
      i_aged[j].order = ORD_W'(sat_sub_order(32'(in_order[j]), 32'(mem_release)));
      i_aged[j].level = LVL_W'(sat_sub_level(32'(in_level[j]), 32'(level_decrease)));
      i_aged[j].data  = in_data[j];
      i_elig[j] = (i_aged[j].order == '0) && (in_level[j] == '0);
      if (in_sel[j] != '0)
        any_in = 1'b1;
      i_live[j] = in_ready && (in_sel[j] != '0) &&
                  !((clear_pipeline && !i_elig[j]) ||
                    (level_clear && (in_level[j] != '0)));
    end
  end

  assign ovf_now = any_in && !in_ready;

  // Compaction: survivors keep age order at the bottom, accepted lanes append.
  // in_ready guarantees room for a full group, so cnt_d never exceeds BUF_LEN.
  always_comb begin
    buf_d  = '0;
    pend_d = '0;
    cnt_d  = '0;
    for (int i = 0; i < BUF_LEN; i++) begin
      if (vld[i] && !b_kill[i] && !b_ret[i]) begin
        buf_d[cnt_d[IDX_W-1:0]] = b_aged[i];
        pend_d[b_aged[i].sel]   = 1'b1;
        cnt_d                   = cnt_d + CNT_W'(1);
      end
    end
    for (int j = 0; j < IN_LEN; j++) begin
      if (i_live[j]) begin
        buf_d[cnt_d[IDX_W-1:0]] = i_aged[j];
        pend_d[i_aged[j].sel]   = 1'b1;
        cnt_d                   = cnt_d + CNT_W'(1);
      end
    end
    pend_d[0] = 1'b0;
  end

  assign ready_d = cnt_d <= CNT_W'(BUF_LEN - IN_LEN);

  // Bank update: retirements younger-last, then direct lanes on top.
  always_comb begin
    bank_d = bank_q;
    for (int i = 0; i < BUF_LEN; i++) begin
      if (b_ret[i])
        bank_d[buf_q[i].sel] = buf_q[i].data;
    end
    for (int m = 0; m < MEM_LEN; m++) begin
      if (wsel[m] != '0)
        bank_d[wsel[m]] = wdata[m];
    end
    bank_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q     <= '0;
      bank_q    <= '0;
      buf_count <= '0;
      pend_list <= '0;
      in_ready  <= 1'b1;
      err_ovf   <= 1'b0;
    end else begin
      buf_q     <= buf_d;
      bank_q    <= bank_d;
      buf_count <= cnt_d;
      pend_list <= pend_d;
      in_ready  <= ready_d;
      if (ovf_now)
        err_ovf <= 1'b1;
    end
  end

  // Read ports.
  logic [BUF_LEN-1:0][RGBIT-1:0] f_sel;
  logic [BUF_LEN-1:0][LVL_W-1:0] f_lvl;
  logic [BUF_LEN-1:0][XLEN-1:0]  f_data;

  always_comb begin
    for (int i = 0; i < BUF_LEN; i++) begin
      f_sel[i]  = buf_q[i].sel;
      f_lvl[i]  = buf_q[i].level;
      f_data[i] = buf_q[i].data;
    end
  end

  for (genvar g = 0; g < RD_PORTS; g++) begin : g_rd
    spec_rf_fwd #(
      .XLEN(XLEN), .NREG(NREG), .BUF_LEN(BUF_LEN), .MEM_LEN(MEM_LEN),
      .LVL_W(LVL_W), .LVL_FILTER(1'b0)
    ) u_fwd (
      .sel(rd_sel[g]), .mem_sel(wsel), .mem_data(wdata),
      .buf_vld(vld), .buf_sel(f_sel), .buf_level(f_lvl), .buf_data(f_data),
      .bank(bank_q), .data(rd_data[g])
    );
  end

  for (genvar g = 0; g < EXTRA_PORTS; g++) begin : g_ex
    spec_rf_fwd #(
      .XLEN(XLEN), .NREG(NREG), .BUF_LEN(BUF_LEN), .MEM_LEN(MEM_LEN),
      .LVL_W(LVL_W), .LVL_FILTER(1'b1)
    ) u_fwd (
      .sel(ex_sel[g]), .mem_sel(wsel), .mem_data(wdata),
      .buf_vld(vld), .buf_sel(f_sel), .buf_level(f_lvl), .buf_data(f_data),
      .bank(bank_q), .data(ex_data[g])
    );
  end

endmodule
